// File: rtl/serial_write_arbiter.sv
// serial_write_arbiter: round-robin share of one serial writer engine.
// The winner's address/data are latched at grant and held until release.
// The engine gets a single wr_start pulse; the owner gets done on wr_ack,
// or err if no ack arrives within TIMEOUT cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; pick next requester after last owner
// ISSUE   | owner latched; raise wr_start for one cycle, clear timer
// WAIT    | waiting for wr_ack or timer to reach TIMEOUT
// RELEASE | done/err pulse visible; drop gnt/busy, remember owner
module serial_write_arbiter #(
   parameter int NREQ    = 4,
   parameter int IW      = 2,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 63,
   parameter int TW      = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic              busy,
   output logic [IW-1:0]     owner,
   output logic              wr_start,
   output logic [AW-1:0]     wr_addr,
   output logic [DW-1:0]     wr_data,
   input  logic              wr_ack
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [NREQ-1:0] err_q, err_d;
   logic            busy_q, busy_d;
   logic            wr_start_q, wr_start_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;

   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand_idx;

   // Round-robin search: first set request strictly after the last owner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand_idx = IW'((int'(last_q) + i) % NREQ);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Next-state and next-output computation for every register.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      last_d     = last_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      busy_d     = busy_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = '0;
      err_d      = '0;
      wr_start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               owner_d        = win_idx;
               wr_addr_d      = req_addr[win_idx*AW +: AW];
               wr_data_d      = req_data[win_idx*DW +: DW];
               busy_d         = 1'b1;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wr_start_d = 1'b1;
            timer_d    = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // Ack takes priority over a timeout landing on the same cycle.
            if (wr_ack) begin
               done_d[owner_q] = 1'b1;
               state_d         = S_RELEASE;
            end else if (timer_q == TW'(TIMEOUT)) begin
               err_d[owner_q] = 1'b1;
               state_d        = S_RELEASE;
            end
         end
         S_RELEASE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         last_q     <= IW'(NREQ - 1);
         owner_q    <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         wr_start_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         wr_start_q <= wr_start_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = busy_q;
   assign owner    = owner_q;
   assign wr_start = wr_start_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_serial_write_arbiter.sv
// Testbench for serial_write_arbiter: the bench plays both the clients and
// the writer engine, and predicts grants/responses from round-robin rules.
`timescale 1ns/1ps
module tb_serial_write_arbiter;
   localparam int NREQ    = 4;
   localparam int IW      = 2;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int TIMEOUT = 63;
   localparam int TW      = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   gnt, done, err;
   logic              busy, wr_start, wr_ack;
   logic [IW-1:0]     owner;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;

   serial_write_arbiter #(.NREQ(NREQ), .IW(IW), .AW(AW), .DW(DW),
                          .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt), .done(done), .err(err), .busy(busy),
      .owner(owner), .wr_start(wr_start), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_last;
   logic [AW-1:0] slot_addr [NREQ];
   logic [DW-1:0] slot_data [NREQ];

   // observations of one transaction
   bit            o_timeout, o_gnt_bad, o_unstable;
   logic [NREQ-1:0] o_gnt, o_done_v, o_err_v;
   logic [IW-1:0] o_owner;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_data;
   int            o_nstart, o_start_cyc, o_resp_cyc, o_ndone, o_nerr;

   task automatic pack_slots();
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = slot_addr[i];
         req_data[i*DW +: DW] = slot_data[i];
      end
   endtask

   task automatic rand_slots();
      for (int i = 0; i < NREQ; i++) begin
         slot_addr[i] = AW'($urandom);
         slot_data[i] = DW'($urandom);
      end
      pack_slots();
   endtask

   function automatic int rr_winner(input logic [NREQ-1:0] m, input int last);
      for (int i = 1; i <= NREQ; i++)
         if (m[(last + i) % NREQ]) return (last + i) % NREQ;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b0; req = '0; wr_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_last = NREQ - 1;
   endtask

   // Acts as the writer engine for one transaction (ack_dly<0: never ack)
   // and as the client that drops req on its done/err.
   task automatic run_txn(input int ack_dly);
      int n, start_at;
      bit got;
      o_timeout = 0; o_gnt_bad = 0; o_unstable = 0;
      o_nstart = 0; o_start_cyc = -1; o_resp_cyc = -1; o_ndone = 0; o_nerr = 0;
      o_done_v = '0; o_err_v = '0; o_gnt = '0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (gnt != '0) got = 1;
      end
      if (!got) begin o_timeout = 1; return; end
      o_gnt = gnt; o_owner = owner; o_addr = wr_addr; o_data = wr_data;
      rand_slots();
      start_at = -1; n = 0;
      while (n < 200) begin
         if (!busy) begin wr_ack = 1'b0; break; end
         if (gnt !== o_gnt) o_gnt_bad = 1;
         if (wr_addr !== o_addr || wr_data !== o_data) o_unstable = 1;
         if (wr_start) begin
            o_nstart++;
            if (start_at < 0) begin start_at = n; o_start_cyc = n; end
         end
         if (done != '0 || err != '0) begin
            if (done != '0) o_ndone++;
            if (err != '0) o_nerr++;
            o_done_v |= done; o_err_v |= err;
            if (o_resp_cyc < 0) o_resp_cyc = n - start_at;
            req = req & ~o_gnt;
         end
         wr_ack = (start_at >= 0 && ack_dly >= 0 && (n - start_at) == ack_dly);
         @(negedge clk);
         n++;
      end
      wr_ack = 1'b0;
      if (n >= 200) o_timeout = 1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({gnt, done, err, busy, owner, wr_start, wr_addr, wr_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got gnt=%b done=%b err=%b busy=%b owner=%0d start=%b addr=%h data=%h expected all 0",
                  gnt, done, err, busy, owner, wr_start, wr_addr, wr_data);
      end
   endtask

   task automatic test_single();
      rand_slots();
      slot_addr[2] = 8'hA5; slot_data[2] = 8'h3C; pack_slots();
      req = 4'b0100;
      run_txn(10);
      checks++; if (o_timeout) begin errors++; $display("FAIL single_timeout got 1 expected 0"); end
      checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b expected 0100", o_gnt); end
      checks++; if (o_addr !== 8'hA5 || o_data !== 8'h3C) begin errors++; $display("FAIL single_addr_data got %h/%h expected a5/3c", o_addr, o_data); end
      checks++; if (o_nstart != 1 || o_start_cyc != 1) begin errors++; $display("FAIL single_start got n=%0d at=%0d expected n=1 at=1", o_nstart, o_start_cyc); end
      checks++; if (o_done_v !== 4'b0100 || o_ndone != 1 || o_resp_cyc != 11) begin errors++; $display("FAIL single_done got %b n=%0d cyc=%0d expected 0100 n=1 cyc=11", o_done_v, o_ndone, o_resp_cyc); end
      checks++; if (o_err_v !== '0) begin errors++; $display("FAIL single_err got %b expected 0000", o_err_v); end
      exp_last = 2;
   endtask

   task automatic test_round_robin();
      int w;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         w = rr_winner(req, exp_last);
         run_txn(int'($urandom_range(0, 5)));
         checks++;
         if (o_timeout || o_gnt !== NREQ'(1 << w) || o_owner !== IW'(w) || o_gnt_bad) begin
            errors++;
            $display("FAIL rr_gnt txn %0d got %b owner %0d expected %b", k, o_gnt, o_owner, NREQ'(1 << w));
         end
         checks++;
         if (o_nstart != 1 || o_done_v !== NREQ'(1 << w)) begin
            errors++;
            $display("FAIL rr_start_done txn %0d got starts=%0d done=%b expected 1/%b", k, o_nstart, o_done_v, NREQ'(1 << w));
         end
         exp_last = w;
         req = req | o_gnt;
      end
   endtask

   task automatic test_priority_wrap();
      req = 4'b0010;
      run_txn(2);
      checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %b expected 0010", o_gnt); end
      exp_last = 1;
      req = 4'b1001;
      run_txn(3);
      checks++; if (o_gnt !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b expected 1000", o_gnt); end
      run_txn(0);
      checks++; if (o_gnt !== 4'b0001 || o_done_v !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b done %b expected 0001", o_gnt, o_done_v); end
      exp_last = 0;
   endtask

   task automatic test_timeout();
      rand_slots();
      req = 4'b0100;
      run_txn(-1);
      checks++;
      if (o_err_v !== 4'b0100 || o_nerr != 1 || o_resp_cyc != TIMEOUT + 1) begin
         errors++;
         $display("FAIL timeout_err got %b n=%0d cyc=%0d expected 0100 n=1 cyc=%0d", o_err_v, o_nerr, o_resp_cyc, TIMEOUT + 1);
      end
      checks++; if (o_ndone != 0) begin errors++; $display("FAIL timeout_done got %0d pulses expected 0", o_ndone); end
      exp_last = 2;
      req = 4'b0001;
      run_txn(5);
      checks++;
      if (o_gnt !== 4'b0001 || o_done_v !== 4'b0001 || o_err_v !== '0 || o_resp_cyc != 6) begin
         errors++;
         $display("FAIL after_timeout got gnt %b done %b err %b cyc %0d expected 0001 0001 0000 6", o_gnt, o_done_v, o_err_v, o_resp_cyc);
      end
      exp_last = 0;
   endtask

   task automatic test_ack_at_timeout();
      int w;
      w = int'($urandom_range(0, NREQ - 1));
      req = NREQ'(1 << w);
      run_txn(TIMEOUT);
      checks++;
      if (o_done_v !== NREQ'(1 << w) || o_err_v !== '0 || o_resp_cyc != TIMEOUT + 1) begin
         errors++;
         $display("FAIL ack_at_timeout got done %b err %b cyc %0d expected %b 0000 %0d", o_done_v, o_err_v, o_resp_cyc, NREQ'(1 << w), TIMEOUT + 1);
      end
      exp_last = w;
   endtask

   task automatic test_reset_mid_and_stray_ack();
      bit seen, bad;
      req = 4'b0010;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (wr_start) seen = 1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL midreset_start got no wr_start expected one"); end
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt, done, err, busy, owner, wr_start, wr_addr, wr_data} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got gnt=%b busy=%b owner=%0d addr=%h expected all 0", gnt, busy, owner, wr_addr);
      end
      reset = 1'b1; req = '0; exp_last = NREQ - 1;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (done != '0 || err != '0 || busy) bad = 1;
      end
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done != '0 || err != '0 || busy || wr_start || gnt != '0) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL stray_ack got activity expected none"); end
      req = 4'b1111;
      run_txn(1);
      checks++; if (o_gnt !== 4'b0001 || o_done_v !== 4'b0001) begin errors++; $display("FAIL post_reset_rr got %b expected 0001", o_gnt); end
      exp_last = 0;
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [NREQ-1:0] m;
      int w, d, exp_resp;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      bit exp_done;
      for (int k = 0; k < 25; k++) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         rand_slots();
         if ($urandom_range(0, 7) == 0) d = -1;
         else if ($urandom_range(0, 2) == 0) d = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3));
         else d = int'($urandom_range(0, 8));
         w = rr_winner(m, exp_last);
         ea = slot_addr[w]; ed = slot_data[w];
         exp_done = (d >= 0 && d <= TIMEOUT);
         exp_resp = exp_done ? d + 1 : TIMEOUT + 1;
         req = m;
         run_txn(d);
         checks++;
         if (o_timeout || o_gnt !== NREQ'(1 << w) || o_gnt_bad || o_addr !== ea || o_data !== ed || o_unstable) begin
            errors++;
            $display("FAIL rand_grant txn %0d got gnt %b addr %h data %h expected %b %h %h", k, o_gnt, o_addr, o_data, NREQ'(1 << w), ea, ed);
         end
         checks++;
         if (o_nstart != 1 || o_resp_cyc != exp_resp ||
             o_done_v !== (exp_done ? NREQ'(1 << w) : NREQ'(0)) ||
             o_err_v !== (exp_done ? NREQ'(0) : NREQ'(1 << w)) ||
             (o_ndone + o_nerr) != 1) begin
            errors++;
            $display("FAIL rand_resp txn %0d d=%0d got done %b err %b cyc %0d expected cyc %0d done=%0d", k, d, o_done_v, o_err_v, o_resp_cyc, exp_resp, exp_done);
         end
         exp_last = w;
         req = '0;
      end
   endtask

   initial begin
      reset = 1'b0; req = '0; wr_ack = 1'b0; req_addr = '0; req_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_priority_wrap();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_and_stray_ack();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
